// File: rtl/fake_pulse_sched_if.sv
// rtl/fake_pulse_sched_if.sv - control, status and fake-sample bundle of fake_pulse_sched; TRIG_OUT present only with FAKE_SCHED_TRIGOUT_EN
interface fake_pulse_sched_if #(
    parameter int NCHAN = 5
);
    logic             START;
    logic             STOP;
    logic [31:0]      INTERVAL;
    logic [11:0]      AMPLITUDE;
    logic [15:0]      NPULSES;
    logic [NCHAN-1:0] CHAN_MASK;
    logic             BUSY;
    logic             DONE;
    logic             PULSE_ACTIVE;
    logic [15:0]      PULSE_COUNT;
    logic [NCHAN-1:0] USE_FAKE;
    logic [23:0]      FAKE_SIGNAL;
`ifdef FAKE_SCHED_TRIGOUT_EN
    logic             TRIG_OUT;
`endif

    // control processor side
    modport master (
`ifdef FAKE_SCHED_TRIGOUT_EN
        input  TRIG_OUT,
`endif
        output START,
        output STOP,
        output INTERVAL,
        output AMPLITUDE,
        output NPULSES,
        output CHAN_MASK,
        input  BUSY,
        input  DONE,
        input  PULSE_ACTIVE,
        input  PULSE_COUNT,
        input  USE_FAKE,
        input  FAKE_SIGNAL
    );

    // scheduler side
    modport slave (
`ifdef FAKE_SCHED_TRIGOUT_EN
        output TRIG_OUT,
`endif
        input  START,
        input  STOP,
        input  INTERVAL,
        input  AMPLITUDE,
        input  NPULSES,
        input  CHAN_MASK,
        output BUSY,
        output DONE,
        output PULSE_ACTIVE,
        output PULSE_COUNT,
        output USE_FAKE,
        output FAKE_SIGNAL
    );
endinterface

// File: rtl/fake_pulse_sched.sv
// rtl/fake_pulse_sched.sv - fake ADC pulse-train scheduler; optional peak marker TRIG_OUT under FAKE_SCHED_TRIGOUT_EN
module fake_pulse_sched #(
    parameter int PEDESTAL   = 200,
    parameter int MAX_SIGNAL = 2047,
    parameter int LG_SHIFT   = 5,
    parameter int NCHAN      = 5
) (
    input logic               CLK,
    input logic               RST,
    fake_pulse_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        WAIT   = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [11:0] PED12    = 12'(PEDESTAL);
    localparam logic [12:0] PED13    = 13'(PEDESTAL);
    localparam logic [12:0] MAX13    = 13'(MAX_SIGNAL);
    localparam logic [23:0] PED_WORD = {PED12, PED12};

    state_t           state;
    logic [31:0]      interval_q;
    logic [11:0]      amp_q;
    logic [15:0]      npulses_q;
    logic [NCHAN-1:0] mask_q;
    logic [31:0]      ic;
    logic [11:0]      r;
    logic [15:0]      pulse_count;
    logic             busy;
    logic             done;
    logic             pulse_active;
    logic [NCHAN-1:0] use_fake;
    logic [23:0]      fake_signal;

    logic             at_boundary;
    logic             more_pulses;
    logic             ramp_last;
    logic             ramp_sample;
    logic [12:0]      hg_sum;
    logic [12:0]      lg_sum;
    logic [11:0]      hg_val;
    logic [11:0]      lg_val;
    logic [11:0]      r_shift;

    // interval boundary and ramp-end decode; ramp_last is only consulted in RAMP where amp_q is non-zero
    assign at_boundary = (ic == (interval_q - 32'd1));
    assign more_pulses = (npulses_q == 16'd0) || (pulse_count < npulses_q);
    assign ramp_last   = (r == (amp_q - 12'd1));
    // a sample is emitted for this cycle's R unless an abort arrives in the same cycle
    assign ramp_sample = (state == RAMP) && !bus.STOP;

    // 13-bit sums, HG saturated, both truncated to 12 bits
    assign r_shift = r >> LG_SHIFT;
    assign hg_sum  = PED13 + {1'b0, r};
    assign lg_sum  = PED13 + {1'b0, r_shift};
    assign hg_val  = (hg_sum > MAX13) ? MAX13[11:0] : hg_sum[11:0];
    assign lg_val  = lg_sum[11:0];

    // run sequencing: configuration latch, interval/ramp counters and registered status outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            interval_q   <= 32'd2;
            amp_q        <= 12'd0;
            npulses_q    <= 16'd0;
            mask_q       <= '0;
            ic           <= 32'd0;
            r            <= 12'd0;
            pulse_count  <= 16'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pulse_active <= 1'b0;
            use_fake     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        interval_q   <= (bus.INTERVAL < 32'd2) ? 32'd2 : bus.INTERVAL;
                        amp_q        <= bus.AMPLITUDE;
                        npulses_q    <= bus.NPULSES;
                        mask_q       <= bus.CHAN_MASK;
                        ic           <= 32'd0;
                        r            <= 12'd0;
                        pulse_count  <= 16'd1;
                        busy         <= 1'b1;
                        use_fake     <= bus.CHAN_MASK;
                        // a zero-length ramp skips straight to the wait phase
                        if (bus.AMPLITUDE == 12'd0) begin
                            state        <= WAIT;
                            pulse_active <= 1'b0;
                        end else begin
                            state        <= RAMP;
                            pulse_active <= 1'b1;
                        end
                    end
                end
                RAMP, WAIT: begin
                    if (bus.STOP) begin
                        state        <= FINISH;
                        done         <= 1'b1;
                        pulse_active <= 1'b0;
                        use_fake     <= '0;
                    end else if (at_boundary) begin
                        if (more_pulses) begin
                            ic          <= 32'd0;
                            r           <= 12'd0;
                            pulse_count <= pulse_count + 16'd1;
                            if (amp_q == 12'd0) begin
                                state        <= WAIT;
                                pulse_active <= 1'b0;
                            end else begin
                                state        <= RAMP;
                                pulse_active <= 1'b1;
                            end
                        end else begin
                            state        <= FINISH;
                            done         <= 1'b1;
                            pulse_active <= 1'b0;
                        end
                    end else begin
                        ic <= ic + 32'd1;
                        if (state == RAMP) begin
                            if (ramp_last) begin
                                state        <= WAIT;
                                pulse_active <= 1'b0;
                            end else begin
                                r <= r + 12'd1;
                            end
                        end
                    end
                end
                FINISH: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    use_fake <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // sample word follows the state/R of the previous cycle
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fake_signal <= PED_WORD;
        end else begin
            fake_signal <= ramp_sample ? {hg_val, lg_val} : PED_WORD;
        end
    end

`ifdef FAKE_SCHED_TRIGOUT_EN
    logic trig_out;

    // marks the sample carrying the ramp peak, whether the ramp ends naturally or at the interval boundary
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            trig_out <= 1'b0;
        end else begin
            trig_out <= ramp_sample && (ramp_last || at_boundary);
        end
    end

    assign bus.TRIG_OUT = trig_out;
`endif

    assign bus.BUSY         = busy;
    assign bus.DONE         = done;
    assign bus.PULSE_ACTIVE = pulse_active;
    assign bus.PULSE_COUNT  = pulse_count;
    assign bus.USE_FAKE     = use_fake;
    assign bus.FAKE_SIGNAL  = fake_signal;

endmodule
